demux_1x4_dispatcher: RTL and testbench
=======================================

Name: demux_1x4_dispatcher

Overview:
Sequenced, registered 1-to-4 stream demultiplexer with valid/ready handshakes on the input and on each output. It groups input words into bursts of BURST words and routes each burst to one channel. The channel comes either from an external select (directed mode) or from an internal round-robin pointer (round-robin mode). It sits in front of the combinational 1x4 demux datapath and replaces bare select lines with a flow-controlled scheduler.

Parameters:
WIDTH, 8, data word width in bits
BURST, 4, words routed to one channel before the target may change (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = directed (use sel), 1 = round-robin
sel  input  2  target channel in directed mode
in_data  input  WIDTH  input word
in_valid  input  1  input word valid
in_ready  output  1  dispatcher can accept in_data this cycle
out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
out_valid  output  4  per-channel word valid
out_ready  input  4  per-channel sink ready
cur_ch  output  2  channel targeted by the current or next word
busy  output  1  burst in progress (burst_cnt != 0)

Behaviour:
- Reset (async, rst=1): all hold slots empty (out_valid=0), out_data=0, burst_cnt=0, rr_ptr=0, mode_q=0, sel_q=0. Therefore cur_ch=0, busy=0, and in_ready=1 once rst deasserts.
- Each channel has a one-entry hold slot (valid bit + data). out_valid[k] is the slot valid bit, and out_data slice k is the slot data.
- Target channel:
  - When burst_cnt==0, tgt = mode ? rr_ptr : sel, taken from the live inputs.
  - When burst_cnt!=0, tgt = mode_q ? rr_ptr : sel_q.
  - cur_ch = tgt.
- Latching: on an accept with burst_cnt==0, capture mode_q<=mode and sel_q<=sel. mode and sel changes during a burst are ignored until the burst ends.
- in_ready = ~hold_v[tgt] | out_ready[tgt]. It is combinational; it must not depend on in_valid.
- Accept = in_valid & in_ready. On accept, hold slot tgt loads in_data and its valid bit is set. The word appears on out_valid/out_data the next cycle (latency 1).
- Drain: slot k clears when out_valid[k] & out_ready[k], unless it is loaded in the same cycle. If load and drain coincide, the new data replaces the old and valid stays 1. Full throughput is 1 word/cycle per channel when the sink is always ready.
- Slots not targeted drain independently. Words already held on other channels are never lost or reordered.
- burst_cnt increments on each accept. On the accept where burst_cnt==BURST-1, it wraps to 0. If the burst was in round-robin mode, rr_ptr advances by 1 mod 4 (3 -> 0).
- rr_ptr never changes in directed mode. The rotation is fixed; a non-ready channel stalls the input and is not skipped.
- BURST=1: every word re-evaluates mode/sel, and round-robin advances on every word.
- busy = (burst_cnt != 0).
- FSM view (burst_cnt plus mode_q):
  - IDLE (cnt=0): accept -> DIRECT or RR per live mode; stays IDLE if BURST=1.
  - DIRECT or RR: accept of the last word -> IDLE.
  - No other transitions.
- Reset mid-burst: partial burst abandoned, held words discarded, rr_ptr returns to 0.
- in_valid low mid-burst: state holds indefinitely, with no timeout.

Decomposition:
- Shared package:
  - NCH=4 and CH_W=2 constants.
  - Mode encodings MODE_DIRECT=0 and MODE_RR=1.
- Sub-module demux_hold_slot (WIDTH): one-entry valid/data register with load/drain/simultaneous rules and async reset. Instantiated 4 times.
- The top level holds burst_cnt, rr_ptr, mode_q/sel_q, target select, and the in_ready mux.

Test Plan:
1. Reset then directed: mode=0, sel=2, BURST=4, out_ready=4'hF, send 0x11..0x14 back-to-back -> out_valid=4'b0100 for 4 cycles starting 1 cycle after each accept. Data 0x11..0x14 in order on slice 2; busy high after the first accept, low after the 4th.
2. Round-robin rotation: mode=1, 16 consecutive words 0x00..0x0F, all ready -> ch0 gets 0x00-0x03, ch1 0x04-0x07, ch2 0x08-0x0B, ch3 0x0C-0x0F. cur_ch ends at 0.
3. Backpressure: directed sel=1, out_ready[1]=0, send 2 words -> first held (out_valid[1]=1), in_ready=0 with the second stalled. Raise out_ready[1] -> second accepted the same cycle, and out_data slice 1 updates next cycle with valid continuous.
4. Mid-burst select change: directed, sel=0, after 2 accepted words set sel=3 -> words 3-4 still go to ch0; word 5 goes to ch3.
5. Simultaneous load/drain on a full slot with out_ready=1: in_ready stays 1, the new word replaces the old in one cycle, and no bubble appears on out_valid.
6. Async reset mid-burst: RR mode, after 6 words assert rst asynchronously between edges -> out_valid=0, busy=0, cur_ch=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/demux_1x4_dispatcher_pkg.sv
// Shared definitions for the 1x4 burst dispatcher.
//   NCH / CH_W : number of output channels and channel-index width
//   mode_e     : directed (external select) vs round-robin target selection
//   next_ch    : round-robin successor, wraps 3 -> 0 through the 2-bit width
package demux_1x4_dispatcher_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return ch + CH_W'(1);
    endfunction

endpackage

// File: rtl/demux_1x4_dispatcher_hold_slot.sv
// One-entry output hold register for a single dispatcher channel.
//   clk, rst : clock, asynchronous active-high reset (empties the slot)
//   load     : capture din this cycle (wins over drain)
//   drain    : sink consumed the held word this cycle
//   din      : word to capture
//   valid    : slot holds a word
//   data     : held word
module demux_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid/data register: a load in the same cycle as a drain keeps valid high
    // so a continuously ready sink sees one word per cycle with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/demux_1x4_dispatcher.sv
// Burst-sequenced 1-to-4 stream dispatcher with valid/ready on every side.
//   clk, rst  : clock, asynchronous active-high reset
//   mode      : 0 = directed (sel picks the channel), 1 = round-robin
//   sel       : directed-mode target channel
//   in_data / in_valid / in_ready : input stream handshake
//   out_data  : channel k word at [k*WIDTH +: WIDTH]
//   out_valid / out_ready : per-channel output handshakes
//   cur_ch    : channel the current or next input word goes to
//   busy      : a burst is partially transferred
// mode/sel are sampled on the first word of a burst and held until the burst's
// BURST-th word is accepted; round-robin never skips a stalled channel.
module demux_1x4_dispatcher
    import demux_1x4_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [1:0]         sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         cur_ch,
    output logic               busy
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    logic [CNT_W-1:0] burst_cnt_r, burst_cnt_n;
    logic [CH_W-1:0]  rr_ptr_r, rr_ptr_n;
    mode_e            mode_q_r, mode_q_n;
    logic [CH_W-1:0]  sel_q_r, sel_q_n;

    mode_e            eff_mode_s;
    logic [CH_W-1:0]  eff_sel_s;
    logic [CH_W-1:0]  tgt_s;
    logic             accept_s;
    logic [NCH-1:0]   hold_v_s;
    logic [NCH-1:0]   load_s;
    logic [NCH-1:0]   drain_s;

    // Target selection: live mode/sel at a burst boundary, latched copies mid-burst.
    always_comb begin
        eff_mode_s = mode_q_r;
        eff_sel_s  = sel_q_r;
        if (burst_cnt_r == '0) begin
            eff_mode_s = mode_e'(mode);
            eff_sel_s  = sel;
        end else begin
            eff_mode_s = mode_q_r;
            eff_sel_s  = sel_q_r;
        end
        if (eff_mode_s == MODE_RR) begin
            tgt_s = rr_ptr_r;
        end else begin
            tgt_s = eff_sel_s;
        end
    end

    // Ready depends only on the target slot, never on in_valid.
    assign in_ready = ~hold_v_s[tgt_s] | out_ready[tgt_s];
    assign accept_s = in_valid & in_ready;
    assign cur_ch   = tgt_s;
    assign busy     = (burst_cnt_r != '0);

    // Burst sequencer next state: latch on first word, wrap and rotate on last.
    always_comb begin
        burst_cnt_n = burst_cnt_r;
        rr_ptr_n    = rr_ptr_r;
        mode_q_n    = mode_q_r;
        sel_q_n     = sel_q_r;
        if (accept_s) begin
            if (burst_cnt_r == '0) begin
                mode_q_n = mode_e'(mode);
                sel_q_n  = sel;
            end else begin
                mode_q_n = mode_q_r;
                sel_q_n  = sel_q_r;
            end
            if (burst_cnt_r == LAST_CNT) begin
                burst_cnt_n = '0;
                if (eff_mode_s == MODE_RR) begin
                    rr_ptr_n = next_ch(rr_ptr_r);
                end else begin
                    rr_ptr_n = rr_ptr_r;
                end
            end else begin
                burst_cnt_n = burst_cnt_r + CNT_W'(1);
            end
        end else begin
            burst_cnt_n = burst_cnt_r;
        end
    end

    // Burst sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_r <= '0;
            rr_ptr_r    <= '0;
            mode_q_r    <= MODE_DIRECT;
            sel_q_r     <= '0;
        end else begin
            burst_cnt_r <= burst_cnt_n;
            rr_ptr_r    <= rr_ptr_n;
            mode_q_r    <= mode_q_n;
            sel_q_r     <= sel_q_n;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign load_s[k]  = accept_s & (tgt_s == CH_W'(k));
        assign drain_s[k] = hold_v_s[k] & out_ready[k];

        demux_hold_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[k]),
            .drain (drain_s[k]),
            .din   (in_data),
            .valid (hold_v_s[k]),
            .data  (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign out_valid = hold_v_s;

endmodule

// File: tb/tb_demux_1x4_dispatcher.sv
module tb_demux_1x4_dispatcher;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         cur_ch;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    demux_1x4_dispatcher #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cur_ch(cur_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic        vin;
        logic [7:0]  din;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [1:0]  exp_cur;
        logic        exp_busy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[13];

    // behavioural reference model state
    logic       m_v[4];
    logic [7:0] m_d[4];
    int         m_pos;
    int         m_rr;
    logic       m_mode_l;
    logic [1:0] m_sel_l;

    task automatic do_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = 8'h00; in_valid = 1'b0; out_ready = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin m_v[k] = 1'b0; m_d[k] = 8'h00; end
        m_pos = 0; m_rr = 0; m_mode_l = 1'b0; m_sel_l = 2'd0;
    endtask

    initial begin
        // mode sel vin din ordy | rdy cur busy(pre) | ov od (post)
        vecs[0]  = '{1'b0, 2'd2, 1'b1, 8'h11, 4'hF, 1'b1, 2'd2, 1'b0, 4'b0100, 32'h0011_0000};
        vecs[1]  = '{1'b0, 2'd2, 1'b1, 8'h12, 4'hF, 1'b1, 2'd2, 1'b1, 4'b0100, 32'h0012_0000};
        vecs[2]  = '{1'b0, 2'd2, 1'b1, 8'h13, 4'hF, 1'b1, 2'd2, 1'b1, 4'b0100, 32'h0013_0000};
        vecs[3]  = '{1'b0, 2'd2, 1'b1, 8'h14, 4'hF, 1'b1, 2'd2, 1'b1, 4'b0100, 32'h0014_0000};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 8'h00, 4'hF, 1'b1, 2'd2, 1'b0, 4'b0000, 32'h0014_0000};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 8'hA1, 4'hD, 1'b1, 2'd1, 1'b0, 4'b0010, 32'h0014_A100};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 8'hA2, 4'hD, 1'b0, 2'd1, 1'b1, 4'b0010, 32'h0014_A100};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 8'hA2, 4'hF, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h0014_A200};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'hF, 1'b1, 2'd1, 1'b1, 4'b0000, 32'h0014_A200};
        vecs[9]  = '{1'b0, 2'd3, 1'b1, 8'hA3, 4'hF, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h0014_A300};
        vecs[10] = '{1'b0, 2'd3, 1'b1, 8'hA4, 4'hF, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h0014_A400};
        vecs[11] = '{1'b0, 2'd3, 1'b1, 8'hB1, 4'hF, 1'b1, 2'd3, 1'b0, 4'b1000, 32'hB114_A400};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 2'd3, 1'b1, 4'b0000, 32'hB114_A400};

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cur_ch", {30'd0, cur_ch}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].vin;
            in_data = vecs[i].din; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_cur_ch", i), {30'd0, cur_ch}, {30'd0, vecs[i].exp_cur});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
        end

        // ---------------- round-robin rotation, 16 words ----------------
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = 1'b1; in_data = 8'(i); out_ready = 4'hF;
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_out_valid", i), {28'd0, out_valid}, 32'd1 << (i / 4));
            chk($sformatf("rr%0d_data", i), {24'd0, out_data[(i/4)*WIDTH +: WIDTH]}, 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rr_end_cur_ch", {30'd0, cur_ch}, 32'd0);
        chk("rr_end_busy", {31'd0, busy}, 32'd0);

        // ---------------- async reset mid-burst ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = 1'b1; in_data = 8'h40 + 8'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_arst_cur_ch", {30'd0, cur_ch}, 32'd1);
        chk("pre_arst_busy", {31'd0, busy}, 32'd1);
        out_ready = 4'h0;
        #1;
        chk("pre_arst_out_valid", {28'd0, out_valid}, 32'b0010);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cur_ch", {30'd0, cur_ch}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 4'hF;

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        model_reset();
        mode = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [1:0]  tgt;
            logic        rdy, acc, eff_mode;
            logic [3:0]  exp_ov;
            logic [31:0] exp_od;
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
            #1;
            eff_mode = (m_pos == 0) ? mode : m_mode_l;
            if (eff_mode) tgt = 2'(m_rr);
            else tgt = (m_pos == 0) ? sel : m_sel_l;
            rdy = !m_v[tgt] || out_ready[tgt];
            for (int k = 0; k < 4; k++) begin
                exp_ov[k] = m_v[k];
                exp_od[k*8 +: 8] = m_d[k];
            end
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, rdy});
            chk("rnd_cur_ch", {30'd0, cur_ch}, {30'd0, tgt});
            chk("rnd_busy", {31'd0, busy}, (m_pos != 0) ? 32'd1 : 32'd0);
            chk("rnd_out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
            chk("rnd_out_data", out_data, exp_od);
            // advance model by one clock
            acc = in_valid && rdy;
            for (int k = 0; k < 4; k++) if (m_v[k] && out_ready[k]) m_v[k] = 1'b0;
            if (acc) begin
                m_v[tgt] = 1'b1;
                m_d[tgt] = in_data;
                if (m_pos == 0) begin m_mode_l = mode; m_sel_l = sel; end
                m_pos = m_pos + 1;
                if (m_pos == BURST) begin
                    m_pos = 0;
                    if (eff_mode) m_rr = (m_rr + 1) % 4;
                end
            end
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
